// File: rtl/vec_mat_mac_seq_if.sv
// rtl/vec_mat_mac_seq_if.sv - operand/result bundle for the vector-matrix MAC engine
interface vec_mat_mac_seq_if #(
  parameter int N  = 8,
  parameter int L  = 8,
  parameter int K  = 8,
  parameter int OW = 2*N+3
);
  logic             start;
  logic             sgn;
  logic             acc;
  logic [L*N-1:0]   a_vec;
  logic [L*K*N-1:0] b_mat;
  logic [K*OW-1:0]  y_vec;
  logic             busy;
  logic             done;

  modport master (
    output start, sgn, acc, a_vec, b_mat,
    input  y_vec, busy, done
  );

  modport slave (
    input  start, sgn, acc, a_vec, b_mat,
    output y_vec, busy, done
  );
endinterface

// File: rtl/vec_mat_mac_seq.sv
// rtl/vec_mat_mac_seq.sv - time-multiplexed y = a^T * B engine, K parallel lanes, one row per cycle
module vec_mat_mac_seq #(
  parameter int N  = 8,
  parameter int L  = 8,
  parameter int K  = 8,
  parameter int OW = 2*N+3
) (
  input logic               clk,
  input logic               rst,
  vec_mat_mac_seq_if.slave  bus
);

  localparam int IW = (L > 1) ? $clog2(L) : 1;
  // Operands are extended to at least OW bits so the low OW bits of the
  // product equal the true (signed or unsigned) product modulo 2^OW.
  localparam int EW = (OW > N) ? OW : N + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [L*N-1:0]         a_q, a_d;
  logic [L*K*N-1:0]       b_q, b_d;
  logic                   sgn_q, sgn_d;
  logic [K-1:0][OW-1:0]   acc_q, acc_d;
  logic [K-1:0][OW-1:0]   y_q, y_d;

  logic [N-1:0]           a_el;
  logic [N-1:0]           b_el;
  logic [EW-1:0]          a_w;
  logic [EW-1:0]          b_w;
  logic [EW-1:0]          prod;
  logic [K-1:0][OW-1:0]   sum;

  // Per-lane MAC datapath for the current row index of the snapshot
  always_comb begin
    sum  = '0;
    b_el = '0;
    b_w  = '0;
    prod = '0;
    a_el = a_q[int'(idx_q)*N +: N];
    a_w  = sgn_q ? {{(EW-N){a_el[N-1]}}, a_el} : {{(EW-N){1'b0}}, a_el};
    for (int j = 0; j < K; j++) begin
      b_el   = b_q[(int'(idx_q)*K + j)*N +: N];
      b_w    = sgn_q ? {{(EW-N){b_el[N-1]}}, b_el} : {{(EW-N){1'b0}}, b_el};
      prod   = a_w * b_w;
      sum[j] = acc_q[j] + prod[OW-1:0];
    end
  end

  // Next-state and register-update logic of the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_vec;
          b_d     = bus.b_mat;
          sgn_d   = bus.sgn;
          acc_d   = bus.acc ? y_q : '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = sum;
        if (idx_q == IW'(L-1)) begin
          y_d     = sum;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot, accumulator and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign bus.y_vec = y_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule
